spi_slave: RTL and testbench
============================

// Module: spi_slave
// PURPOSE
//  SPI slave endpoint for the 18-bit single-slave link driven by spi_master.
//  Oversamples sclk/ss_n/mosi in the sys_clock domain and deserialises 18-bit LSB-first frames onto slave_out.
//  Shifts a preloaded 18-bit word out on miso in the same frame. Supports all four SPI modes.
//  Sits at the slave end of the link, with its sclk/ss_n/mosi/miso wired directly to the master's pins.
// PARAMETERS
//  DATA_WIDTH   18  frame length in bits; counters sized $clog2(DATA_WIDTH+1)
//  SYNC_STAGES  2   flip-flop stages on each of sclk, ss_n and mosi (>=2)
// PORTS
//  sys_clock       in   1   system clock; sole clock; sys_clock freq >= 8x sclk freq
//  reset_n         in   1   asynchronous, active-low reset
//  spi_mode        in   2   [1]=CPOL, [0]=CPHA; captured on ss_n falling edge, held for the frame
//  tx_load         in   1   pulse: latch tx_data as the next frame's miso word
//  tx_data         in   18  word to transmit, LSB first
//  sclk            in   1   serial clock from master (async)
//  ss_n            in   1   active-low slave select (async)
//  mosi            in   1   serial data from master (async)
//  miso            out  1   serial data to master
//  slave_out       out  18  last complete received frame
//  srx_data_valid  out  1   1-cycle pulse: slave_out updated
//  tx_busy         out  1   high while a frame is in progress; tx_load ignored
//  frame_error     out  1   1-cycle pulse: ss_n rose before 18 bits were sampled
// BEHAVIOUR
//  Reset values: miso=1, slave_out=0, srx_data_valid=0, tx_busy=0, frame_error=0, tx buffer=18'h3FFFF, state=IDLE, armed=0.
//  Sync/edge detect: SYNC_STAGES flops on each input, plus one history flop each; edges are detected on the synced values.
//  Lead edge = rising if CPOL=0, falling if CPOL=1; trail edge = the opposite.
//  CPHA=0: sample mosi on lead, shift miso on trail; bit0 is driven on miso the cycle after ss_n fall is detected.
//  CPHA=1: shift miso on lead (first lead drives bit0), sample mosi on trail.
//  FSM states:
//   IDLE: miso=1, tx_busy=0. armed is set once synced ss_n=1 is seen.
//     Synced ss_n falling while armed -> ACTIVE: latch spi_mode, bit counters=0, tx_busy=1.
//   ACTIVE: rx shift reg fills LSB-first (new bit enters [17], shift right). rx counter increments per sample edge.
//     tx shift reg shifts right, filling with 1. tx counter saturates at 18.
//     rx counter reaches 18 -> DONE.
//     Synced ss_n rise with rx counter <18 -> frame_error pulse; slave_out unchanged; go to IDLE.
//   DONE: slave_out <= rx shift reg and srx_data_valid pulses in the same cycle the 18th sample is taken.
//     Further sclk edges are ignored. miso=1. Synced ss_n rise -> IDLE.
//  Latency: 18th sample edge at pin -> srx_data_valid within SYNC_STAGES+2 sys_clock cycles.
//    Shift edge at pin -> miso update within SYNC_STAGES+2 cycles.
//  TX buffer:
//   - tx_load in IDLE latches tx_data. Multiple loads: last one wins.
//   - tx_load in the same cycle as the ss_n-fall detect: the new word is used for this frame.
//   - tx_load while tx_busy=1: ignored.
//   - The buffer reverts to 18'h3FFFF after each frame (complete or aborted), so an unloaded frame sends all ones.
//  spi_mode changes while tx_busy=1 have no effect until the next frame.
//  reset_n asserted mid-frame: immediate return to reset values. armed=0, so a frame still in progress
//    (ss_n low) is ignored until ss_n has been seen high.
//  Back-to-back frames: ss_n high for >= SYNC_STAGES+2 sys_clock cycles between frames is required and sufficient.
// TESTING
//  Mode 0, tx_load 18'h2A5A5, master sends 18'h15A5A -> slave_out=18'h15A5A,
//    one srx_data_valid pulse, master receives 18'h2A5A5.
//  Modes 1, 2, 3 each with mosi 18'h00001 and miso 18'h20000 -> both ends receive the exact words; LSB/MSB placement correct.
//  No tx_load before frame -> master receives 18'h3FFFF; second frame after a loaded one also returns 18'h3FFFF.
//  ss_n raised after 9 bits -> frame_error pulse, srx_data_valid stays 0, slave_out keeps its prior value;
//    the next full frame of 18'h00ABC is received correctly.
//  reset_n pulsed low at bit 7 while ss_n stays low -> miso=1, rest of frame ignored, no valid/error pulses;
//    next frame after ss_n high is received correctly.
//  tx_load 18'h1FFFF during an active frame -> ignored for the current and next frame; next frame returns 18'h3FFFF.

Source files
------------

// File: rtl/spi_slave.sv
// SPI slave endpoint: oversamples sclk/ss_n/mosi in the sys_clock domain, receives LSB-first frames
// onto slave_out and shifts a preloaded word out on miso. All four SPI modes are supported.
module spi_slave #(
  parameter int unsigned DATA_WIDTH  = 18,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  sys_clock,
  input  logic                  reset_n,
  input  logic [1:0]            spi_mode,
  input  logic                  tx_load,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  sclk,
  input  logic                  ss_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic [DATA_WIDTH-1:0] slave_out,
  output logic                  srx_data_valid,
  output logic                  tx_busy,
  output logic                  frame_error
);

  localparam int unsigned CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t                state;
  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic                  sclk_d, ss_d;
  logic                  armed;
  logic [1:0]            mode_q;
  logic [DATA_WIDTH-1:0] rx_sr, tx_sr, tx_buf;
  logic [CW-1:0]         rx_cnt, tx_cnt;

  logic sclk_s, ss_s, mosi_s;
  logic sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic lead_edge, trail_edge, sample_edge, shift_edge;
  logic [DATA_WIDTH-1:0] load_word;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign ss_rise   = ss_s & ~ss_d;
  assign ss_fall   = ~ss_s & ss_d;

  // Lead/trail follow CPOL; CPHA picks which of them samples and which shifts
  assign lead_edge   = mode_q[1] ? sclk_fall : sclk_rise;
  assign trail_edge  = mode_q[1] ? sclk_rise : sclk_fall;
  assign sample_edge = mode_q[0] ? trail_edge : lead_edge;
  assign shift_edge  = mode_q[0] ? lead_edge : trail_edge;

  // A load coinciding with the frame start goes straight into this frame
  assign load_word = tx_load ? tx_data : tx_buf;

  // Input synchronisers; ss_n chain resets low so a frame in flight at reset never arms the slave
  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync <= '0;
      ss_sync   <= '0;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      ss_d      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_s;
      ss_d      <= ss_s;
    end
  end

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      armed          <= 1'b0;
      mode_q         <= 2'b00;
      rx_sr          <= '0;
      tx_sr          <= '1;
      tx_buf         <= '1;
      rx_cnt         <= '0;
      tx_cnt         <= '0;
      miso           <= 1'b1;
      slave_out      <= '0;
      srx_data_valid <= 1'b0;
      tx_busy        <= 1'b0;
      frame_error    <= 1'b0;
    end else begin
      srx_data_valid <= 1'b0;
      frame_error    <= 1'b0;
      case (state)
        IDLE: begin
          miso    <= 1'b1;
          tx_busy <= 1'b0;
          if (ss_s) armed <= 1'b1;
          if (tx_load) tx_buf <= tx_data;
          if (ss_fall && armed) begin
            state   <= ACTIVE;
            mode_q  <= spi_mode;
            rx_cnt  <= '0;
            tx_cnt  <= '0;
            tx_busy <= 1'b1;
            tx_buf  <= '1;
            if (spi_mode[0]) begin
              tx_sr <= load_word;
            end else begin
              miso  <= load_word[0];
              tx_sr <= {1'b1, load_word[DATA_WIDTH-1:1]};
            end
          end
        end
        ACTIVE: begin
          if (ss_rise) begin
            frame_error <= 1'b1;
            miso        <= 1'b1;
            state       <= IDLE;
          end else begin
            if (shift_edge && tx_cnt != CW'(DATA_WIDTH)) begin
              miso   <= tx_sr[0];
              tx_sr  <= {1'b1, tx_sr[DATA_WIDTH-1:1]};
              tx_cnt <= tx_cnt + CW'(1);
            end
            if (sample_edge) begin
              rx_sr  <= {mosi_s, rx_sr[DATA_WIDTH-1:1]};
              rx_cnt <= rx_cnt + CW'(1);
              if (rx_cnt == CW'(DATA_WIDTH - 1)) begin
                slave_out      <= {mosi_s, rx_sr[DATA_WIDTH-1:1]};
                srx_data_valid <= 1'b1;
                miso           <= 1'b1;
                state          <= DONE;
              end
            end
          end
        end
        DONE: begin
          miso <= 1'b1;
          if (ss_rise) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a behavioural SPI master drives frames, a queue holds expected slave_out words.
module tb_spi_slave;

  localparam int unsigned DW   = 18;
  localparam int unsigned HALF = 8;

  logic          sys_clock = 1'b0;
  logic          reset_n   = 1'b0;
  logic [1:0]    spi_mode  = 2'b00;
  logic          tx_load   = 1'b0;
  logic [DW-1:0] tx_data   = '0;
  logic          sclk      = 1'b0;
  logic          ss_n      = 1'b1;
  logic          mosi      = 1'b0;
  logic          miso;
  logic [DW-1:0] slave_out;
  logic          srx_data_valid;
  logic          tx_busy;
  logic          frame_error;

  int vectors     = 0;
  int miscompares = 0;
  int valid_cnt   = 0;
  int err_cnt     = 0;
  logic [DW-1:0] exp_q[$];

  spi_slave #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
    .sys_clock      (sys_clock),
    .reset_n        (reset_n),
    .spi_mode       (spi_mode),
    .tx_load        (tx_load),
    .tx_data        (tx_data),
    .sclk           (sclk),
    .ss_n           (ss_n),
    .mosi           (mosi),
    .miso           (miso),
    .slave_out      (slave_out),
    .srx_data_valid (srx_data_valid),
    .tx_busy        (tx_busy),
    .frame_error    (frame_error)
  );

  always #5 sys_clock = ~sys_clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Scoreboard side: every valid pulse must match the oldest expected word
  always @(negedge sys_clock) begin
    if (frame_error) err_cnt++;
    if (srx_data_valid) begin
      valid_cnt++;
      vectors++;
      assert (exp_q.size() > 0) else begin
        miscompares++;
        $error("FAIL unexpected_valid: observed %0h expected no pulse", slave_out);
      end
      if (exp_q.size() > 0) check("slave_out_sb", 32'(slave_out), 32'(exp_q.pop_front()));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clock);
    #1;
  endtask

  task automatic load(input logic [DW-1:0] w);
    tx_data = w;
    tx_load = 1'b1;
    tick(1);
    tx_load = 1'b0;
  endtask

  // Behavioural master; rst_bit >= 0 pulses reset_n just before that bit's lead edge
  task automatic spi_xfer(input logic [1:0] mode, input logic [DW-1:0] mo, input int nbits,
                          input int rst_bit, output logic [DW-1:0] mi);
    logic cpol, cpha;
    cpol = mode[1];
    cpha = mode[0];
    mi = '1;
    spi_mode = mode;
    sclk = cpol;
    ss_n = 1'b1;
    tick(8);
    ss_n = 1'b0;
    if (!cpha) mosi = mo[0];
    tick(HALF);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_bit) begin
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
      end
      sclk = ~cpol;
      if (cpha) mosi = mo[i];
      else mi[i] = miso;
      tick(HALF);
      sclk = cpol;
      if (cpha) mi[i] = miso;
      else if (i + 1 < nbits) mosi = mo[i + 1];
      tick(HALF);
    end
    ss_n = 1'b1;
    tick(12);
  endtask

  logic [DW-1:0] mi;
  logic [DW-1:0] last_rx;
  int v0, e0;

  initial begin
    tick(3);
    check("rst_miso", 32'(miso), 32'd1);
    check("rst_slave_out", 32'(slave_out), 32'd0);
    check("rst_valid", 32'(srx_data_valid), 32'd0);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_frame_error", 32'(frame_error), 32'd0);
    reset_n = 1'b1;
    tick(6);

    // Mode 0 basic frame
    load(18'h2A5A5);
    v0 = valid_cnt; e0 = err_cnt;
    exp_q.push_back(18'h15A5A);
    spi_xfer(2'b00, 18'h15A5A, DW, -1, mi);
    check("m0_miso_word", 32'(mi), 32'h2A5A5);
    check("m0_slave_out", 32'(slave_out), 32'h15A5A);
    check("m0_valid_pulses", 32'(valid_cnt - v0), 32'd1);
    check("m0_no_error", 32'(err_cnt - e0), 32'd0);
    check("m0_busy_after", 32'(tx_busy), 32'd0);

    // Modes 1..3 with single-bit words at opposite ends
    for (int m = 1; m < 4; m++) begin
      load(18'h20000);
      exp_q.push_back(18'h00001);
      spi_xfer(2'(m), 18'h00001, DW, -1, mi);
      check($sformatf("m%0d_miso_word", m), 32'(mi), 32'h20000);
      check($sformatf("m%0d_slave_out", m), 32'(slave_out), 32'h00001);
    end

    // Frame after a loaded one with no new load sends all ones
    exp_q.push_back(18'h12345);
    spi_xfer(2'b00, 18'h12345, DW, -1, mi);
    check("unloaded_miso", 32'(mi), 32'h3FFFF);
    last_rx = 18'h12345;

    // Abort after 9 bits
    load(18'h0F00F);
    v0 = valid_cnt; e0 = err_cnt;
    spi_xfer(2'b00, 18'h3C3C3, 9, -1, mi);
    check("abort_error_pulse", 32'(err_cnt - e0), 32'd1);
    check("abort_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("abort_slave_out_kept", 32'(slave_out), 32'(last_rx));
    exp_q.push_back(18'h00ABC);
    spi_xfer(2'b00, 18'h00ABC, DW, -1, mi);
    check("after_abort_rx", 32'(slave_out), 32'h00ABC);
    check("after_abort_miso", 32'(mi), 32'h3FFFF);

    // Reset pulsed at bit 7 while ss_n stays low
    load(18'h00000);
    v0 = valid_cnt; e0 = err_cnt;
    spi_xfer(2'b00, 18'h2AAAA, DW, 7, mi);
    check("rst_mid_low_bits", 32'(mi[6:0]), 32'h00);
    check("rst_mid_miso_high", 32'(mi[17:7]), 32'h7FF);
    check("rst_mid_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("rst_mid_no_error", 32'(err_cnt - e0), 32'd0);
    check("rst_mid_slave_out", 32'(slave_out), 32'd0);
    load(18'h13579);
    exp_q.push_back(18'h2468A);
    spi_xfer(2'b11, 18'h2468A, DW, -1, mi);
    check("post_rst_rx", 32'(slave_out), 32'h2468A);
    check("post_rst_miso", 32'(mi), 32'h13579);

    // tx_load during an active frame is ignored now and for the next frame
    exp_q.push_back(18'h0F0F0);
    fork
      spi_xfer(2'b00, 18'h0F0F0, DW, -1, mi);
      begin
        tick(120);
        check("busy_mid_frame", 32'(tx_busy), 32'd1);
        load(18'h1FFFF);
      end
    join
    check("busy_load_cur", 32'(mi), 32'h3FFFF);
    exp_q.push_back(18'h30303);
    spi_xfer(2'b10, 18'h30303, DW, -1, mi);
    check("busy_load_next", 32'(mi), 32'h3FFFF);
    check("busy_load_next_rx", 32'(slave_out), 32'h30303);

    tick(4);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
